lab2_control_unit: RTL and testbench
====================================

Name: lab2_control_unit

Overview:
- FSM controller that drives the CTRL_* strobes of the lab2 add/display datapath. It is the control end of the datapath's CTRL interface.
- Qualifies a user "Enter" push-button (synchronise, debounce, one-shot), then sequences: clear, load operand A, load operand B.
- Then alternately strobes the most-significant and least-significant display-digit loads until the next press restarts the sequence.

Parameters:
- DEBOUNCE_CYCLES, default 16: consecutive synchronised samples of a new button level required before it is accepted (minimum 2).
- DISP_PERIOD, default 8: cycles between successive digit-load strobes in S_SHOW (minimum 2).

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RESET  input  1  synchronous, active-high reset.
- BTN_Enter  input  1  raw, asynchronous, bouncing push-button; high = pressed.
- CTRL_Init  output  1  one-cycle datapath clear strobe.
- CTRL_LoadA  output  1  one-cycle strobe: capture INPUT_Number as operand A.
- CTRL_LoadB  output  1  one-cycle strobe: capture INPUT_Number as operand B.
- CTRL_LoadMS  output  1  one-cycle strobe: present MS digit.
- CTRL_LoadLS  output  1  one-cycle strobe: present LS digit.
- STATE_Code  output  3  current state encoding, for LEDs.
- BUSY  output  1  high in S_INIT, S_LOAD_A and S_LOAD_B.

Behaviour:
- Clock and reset: one clock (CLK). RESET is synchronous and active-high.
- Outputs: all registered; all are 0 while RESET is high.
- At most one CTRL_* output is high in any cycle.
- Input path: BTN_Enter passes through a 2-flop synchroniser.
- Debounce:
  - btn_stable resets to 1, so a button held through reset cannot fire a press.
  - A counter increments while the synchronised level differs from btn_stable, and clears to 0 when they match.
  - On the DEBOUNCE_CYCLES-th consecutive differing sample, btn_stable takes the new level and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES produces no change.
- press_evt: registered one-cycle pulse on a btn_stable 0->1 transition. A new press requires an accepted release first.
- Press latency: CTRL_LoadA (or CTRL_LoadB) rises exactly DEBOUNCE_CYCLES+4 rising edges after the first edge that samples BTN_Enter high, with the button held clean.
- States (STATE_Code value in brackets):
  - S_INIT [0]: CTRL_Init=1 for exactly one cycle. Entered on the first edge with RESET low, then -> S_WAIT_A.
  - S_WAIT_A [1]: wait for press_evt -> S_LOAD_A.
  - S_LOAD_A [2]: CTRL_LoadA=1 for one cycle -> S_WAIT_B.
  - S_WAIT_B [3]: wait for press_evt -> S_LOAD_B.
  - S_LOAD_B [4]: CTRL_LoadB=1 for one cycle -> S_SHOW.
  - S_SHOW [5]:
    - On the entry cycle, CTRL_LoadMS=1 and the display counter loads 0.
    - Each time the counter reaches DISP_PERIOD-1 it wraps to 0 and strobes the opposite digit from the previous strobe. The sequence is MS, LS, MS, ...
    - press_evt -> S_INIT.
- Codes 6 and 7 are unreachable; if ever entered, the next state is S_INIT.
- Simultaneous events:
  - press_evt in the same cycle as a display wrap: the press wins, no digit strobe is issued, next state is S_INIT.
  - press_evt cannot coincide with a LOAD state, because press spacing is at least 2*DEBOUNCE_CYCLES.
- Reset mid-operation: state returns to reset condition and the sequence restarts from S_INIT after release. Synchroniser, debounce counter, display counter and digit toggle all clear; btn_stable returns to 1.
- Width rules:
  - Debounce counter is $clog2(DEBOUNCE_CYCLES+1) bits and saturates (never wraps).
  - Display counter is $clog2(DISP_PERIOD) bits.

Decomposition:
- Package lab2_ctrl_pkg: state enum/localparams S_INIT..S_SHOW with the codes above, and the STATE_Code width.
- Sub-module lab2_button_debounce (CLK, RESET, btn_raw -> press_evt): contains the synchroniser, debounce counter, btn_stable and the one-shot.
- The top level holds the FSM, the display counter and the output registers.

Test Plan (DEBOUNCE_CYCLES=4, DISP_PERIOD=8):
- Reset release with BTN_Enter low: CTRL_Init=1 on exactly the first cycle, STATE_Code=0 then 1. All other CTRL outputs stay 0 for 200 cycles.
- Clean press held 20 cycles after 10 idle cycles: CTRL_LoadA pulses once, 8 edges after the first sampled high; STATE_Code 1->2->3. A second clean press gives one CTRL_LoadB pulse, STATE_Code 3->4->5.
- Bounce: BTN_Enter toggles high/low every 2 cycles for 30 cycles, then settles high: no strobe during bouncing; exactly one CTRL_LoadA, 8 edges after the last settling edge.
- S_SHOW run for 40 cycles: CTRL_LoadMS at entry (t=0) and t=16, 32; CTRL_LoadLS at t=8, 24. Never both high in one cycle.
- Press accepted in S_SHOW on a display-wrap cycle: no digit strobe that cycle; next cycle CTRL_Init=1, STATE_Code=0, then 1.
- RESET asserted in S_WAIT_B with BTN_Enter held high, then released:
  - All outputs 0 during reset; CTRL_Init pulses once after release.
  - No CTRL_LoadA until the button is released for at least 4 cycles and pressed again.

Source files
------------

// File: rtl/lab2_ctrl_pkg.sv
// lab2_ctrl_pkg
// Shared definitions for the lab2 control unit: the FSM state encoding and
// the width of the STATE_Code output that mirrors it onto the board LEDs.
// The state codes are fixed because the LED decoding on the board depends
// on them. Codes 6 and 7 are never used.

package lab2_ctrl_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        S_INIT   = 3'd0,
        S_WAIT_A = 3'd1,
        S_LOAD_A = 3'd2,
        S_WAIT_B = 3'd3,
        S_LOAD_B = 3'd4,
        S_SHOW   = 3'd5
    } state_t;

endpackage

// File: rtl/lab2_button_debounce.sv
// lab2_button_debounce
// Turns the raw, bouncing Enter push-button into a clean one-cycle press
// event.
//
// Ports:
//   CLK        system clock, rising edge
//   RESET      synchronous, active-high reset
//   btn_raw    raw asynchronous button level, high = pressed
//   press_evt  registered one-cycle pulse per accepted press (0->1 of the
//              debounced level)
//
// The debounced level resets to 1 (pressed), so a button held through reset
// must first be seen released before a new press can be reported.

module lab2_button_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic CLK,
    input  logic RESET,
    input  logic btn_raw,
    output logic press_evt
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(DEBOUNCE_CYCLES);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_q, stable_d;
    logic             stable_prev_q, stable_prev_d;
    logic             press_evt_q, press_evt_d;

    // Synchroniser, debounce counter and one-shot next-state logic.
    // The counter only runs while the synchronised level disagrees with the
    // accepted level; the sample that would be the DEBOUNCE_CYCLES-th
    // disagreement flips the accepted level instead of counting further.
    // The edge detector compares against a delayed copy of the accepted
    // level so the press pulse itself comes out of a register.
    always_comb begin
        sync1_d       = btn_raw;
        sync2_d       = sync1_q;
        stable_d      = stable_q;
        cnt_d         = '0;
        stable_prev_d = stable_q;
        press_evt_d   = stable_q & ~stable_prev_q;

        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
                cnt_d    = '0;
            end else if (cnt_q != CNT_SAT) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                cnt_d = cnt_q;
            end
        end
    end

    // State registers; the accepted level and its delayed copy reset to
    // "pressed" so no event can come out of a button held through reset.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            cnt_q         <= '0;
            stable_q      <= 1'b1;
            stable_prev_q <= 1'b1;
            press_evt_q   <= 1'b0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            cnt_q         <= cnt_d;
            stable_q      <= stable_d;
            stable_prev_q <= stable_prev_d;
            press_evt_q   <= press_evt_d;
        end
    end

    assign press_evt = press_evt_q;

endmodule

// File: rtl/lab2_control_unit.sv
// lab2_control_unit
// Control end of the lab2 add/display datapath. Each qualified Enter press
// advances the sequence clear -> load A -> load B -> show; while showing, the
// MS and LS display digits are strobed alternately every DISP_PERIOD cycles
// until the next press restarts from the clear.
//
// Ports:
//   CLK          system clock, rising edge
//   RESET        synchronous, active-high reset
//   BTN_Enter    raw bouncing push-button, high = pressed
//   CTRL_Init    one-cycle datapath clear strobe
//   CTRL_LoadA   one-cycle operand A capture strobe
//   CTRL_LoadB   one-cycle operand B capture strobe
//   CTRL_LoadMS  one-cycle MS display-digit strobe
//   CTRL_LoadLS  one-cycle LS display-digit strobe
//   STATE_Code   state encoding for the LEDs
//   BUSY         high while clearing or loading operands
//
// Every output is a register decoded from the current state, so the outputs
// trail the state register by one cycle and are glitch-free at the datapath.

module lab2_control_unit
    import lab2_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int DISP_PERIOD     = 8
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               BTN_Enter,
    output logic               CTRL_Init,
    output logic               CTRL_LoadA,
    output logic               CTRL_LoadB,
    output logic               CTRL_LoadMS,
    output logic               CTRL_LoadLS,
    output logic [STATE_W-1:0] STATE_Code,
    output logic               BUSY
);

    localparam int DISP_W = $clog2(DISP_PERIOD);
    localparam logic [DISP_W-1:0] DISP_LAST = DISP_W'(DISP_PERIOD - 1);

    logic press_evt;

    state_t              state_q, state_d;
    logic [DISP_W-1:0]   disp_cnt_q, disp_cnt_d;
    logic                show_entry_q, show_entry_d;
    logic                next_ls_q, next_ls_d;

    logic                init_q, init_d;
    logic                load_a_q, load_a_d;
    logic                load_b_q, load_b_d;
    logic                load_ms_q, load_ms_d;
    logic                load_ls_q, load_ls_d;
    logic [STATE_W-1:0]  code_q, code_d;
    logic                busy_q, busy_d;

    lab2_button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .CLK      (CLK),
        .RESET    (RESET),
        .btn_raw  (BTN_Enter),
        .press_evt(press_evt)
    );

    // Next state, display counter and output decode.
    // show_entry marks the first cycle in S_SHOW so the MS digit is strobed
    // immediately and the counter restarts from 0; after that a strobe is
    // issued on every counter wrap, alternating digits via next_ls. A press
    // in S_SHOW takes priority over a wrap in the same cycle.
    always_comb begin
        state_d      = state_q;
        disp_cnt_d   = disp_cnt_q;
        show_entry_d = 1'b0;
        next_ls_d    = next_ls_q;
        init_d       = 1'b0;
        load_a_d     = 1'b0;
        load_b_d     = 1'b0;
        load_ms_d    = 1'b0;
        load_ls_d    = 1'b0;
        code_d       = state_q;
        busy_d       = 1'b0;

        case (state_q)
            S_INIT: begin
                init_d  = 1'b1;
                busy_d  = 1'b1;
                state_d = S_WAIT_A;
            end
            S_WAIT_A: begin
                if (press_evt) begin
                    state_d = S_LOAD_A;
                end
            end
            S_LOAD_A: begin
                load_a_d = 1'b1;
                busy_d   = 1'b1;
                state_d  = S_WAIT_B;
            end
            S_WAIT_B: begin
                if (press_evt) begin
                    state_d = S_LOAD_B;
                end
            end
            S_LOAD_B: begin
                load_b_d     = 1'b1;
                busy_d       = 1'b1;
                state_d      = S_SHOW;
                show_entry_d = 1'b1;
            end
            S_SHOW: begin
                if (press_evt) begin
                    state_d = S_INIT;
                end else if (show_entry_q) begin
                    load_ms_d  = 1'b1;
                    disp_cnt_d = '0;
                    next_ls_d  = 1'b1;
                end else if (disp_cnt_q == DISP_LAST) begin
                    disp_cnt_d = '0;
                    load_ls_d  = next_ls_q;
                    load_ms_d  = ~next_ls_q;
                    next_ls_d  = ~next_ls_q;
                end else begin
                    disp_cnt_d = disp_cnt_q + DISP_W'(1);
                end
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    // State and output registers; reset parks the FSM in S_INIT with all
    // outputs low so the clear strobe appears right after reset release.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q      <= S_INIT;
            disp_cnt_q   <= '0;
            show_entry_q <= 1'b0;
            next_ls_q    <= 1'b0;
            init_q       <= 1'b0;
            load_a_q     <= 1'b0;
            load_b_q     <= 1'b0;
            load_ms_q    <= 1'b0;
            load_ls_q    <= 1'b0;
            code_q       <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            disp_cnt_q   <= disp_cnt_d;
            show_entry_q <= show_entry_d;
            next_ls_q    <= next_ls_d;
            init_q       <= init_d;
            load_a_q     <= load_a_d;
            load_b_q     <= load_b_d;
            load_ms_q    <= load_ms_d;
            load_ls_q    <= load_ls_d;
            code_q       <= code_d;
            busy_q       <= busy_d;
        end
    end

    assign CTRL_Init   = init_q;
    assign CTRL_LoadA  = load_a_q;
    assign CTRL_LoadB  = load_b_q;
    assign CTRL_LoadMS = load_ms_q;
    assign CTRL_LoadLS = load_ls_q;
    assign STATE_Code  = code_q;
    assign BUSY        = busy_q;

endmodule

// File: tb/tb_lab2_control_unit.sv
// tb_lab2_control_unit
// Directed bench for lab2_control_unit with DEBOUNCE_CYCLES=4 and
// DISP_PERIOD=8. Inputs are driven on the falling edge, outputs are sampled
// 1 time unit after each rising edge. Output vector layout:
// {init, loadA, loadB, loadMS, loadLS, code[2:0], busy}.

module tb_lab2_control_unit;

    logic       CLK;
    logic       RESET;
    logic       BTN_Enter;
    logic       CTRL_Init;
    logic       CTRL_LoadA;
    logic       CTRL_LoadB;
    logic       CTRL_LoadMS;
    logic       CTRL_LoadLS;
    logic [2:0] STATE_Code;
    logic       BUSY;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic       btn;
        logic [8:0] exp;
    } vec_t;

    localparam int NUM_VECS = 134;
    vec_t vecs [NUM_VECS];

    lab2_control_unit #(
        .DEBOUNCE_CYCLES(4),
        .DISP_PERIOD    (8)
    ) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .BTN_Enter  (BTN_Enter),
        .CTRL_Init  (CTRL_Init),
        .CTRL_LoadA (CTRL_LoadA),
        .CTRL_LoadB (CTRL_LoadB),
        .CTRL_LoadMS(CTRL_LoadMS),
        .CTRL_LoadLS(CTRL_LoadLS),
        .STATE_Code (STATE_Code),
        .BUSY       (BUSY)
    );

    // Free-running clock, period 10.
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Packs expected output fields in the same order as the DUT snapshot.
    function automatic logic [8:0] pk(input logic init, input logic la,
                                      input logic lb, input logic ms,
                                      input logic ls, input logic [2:0] code,
                                      input logic busy);
        return {init, la, lb, ms, ls, code, busy};
    endfunction

    // Drives one cycle of inputs and advances to just after the next edge.
    task automatic applyStimulus(input logic rst, input logic btn);
        @(negedge CLK);
        RESET     = rst;
        BTN_Enter = btn;
        @(posedge CLK);
        #1;
    endtask

    // Compares the full output snapshot against the expected vector.
    task automatic checkOutput(input string name, input logic [8:0] exp);
        logic [8:0] act;
        act = {CTRL_Init, CTRL_LoadA, CTRL_LoadB, CTRL_LoadMS, CTRL_LoadLS,
               STATE_Code, BUSY};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=%b required=%b (init,lA,lB,MS,LS,code,busy)",
                     name, act, exp);
        end
    endtask

    initial begin
        logic       b;
        logic [2:0] code;

        RESET     = 1'b1;
        BTN_Enter = 1'b0;

        // Main table: reset, clear, press A, press B, S_SHOW digit strobes,
        // then a press landing exactly on a display-wrap cycle.
        // Presses are sampled high from index 12, 44 and 102; the strobe
        // appears 8 edges later. S_SHOW is entered at index 53.
        for (int i = 0; i < NUM_VECS; i++) begin
            vecs[i].rst = (i < 2);
            vecs[i].btn = (i >= 12 && i < 32) || (i >= 44 && i < 64) ||
                          (i >= 102 && i < 122);
            if (i < 3)        code = 3'd0;
            else if (i < 20)  code = 3'd1;
            else if (i == 20) code = 3'd2;
            else if (i < 52)  code = 3'd3;
            else if (i == 52) code = 3'd4;
            else if (i < 110) code = 3'd5;
            else if (i == 110) code = 3'd0;
            else              code = 3'd1;
            vecs[i].exp = pk((i == 2) || (i == 110),
                             (i == 20),
                             (i == 52),
                             (i == 53) || (i == 69) || (i == 85) || (i == 101),
                             (i == 61) || (i == 77) || (i == 93),
                             code,
                             (i == 2) || (i == 20) || (i == 52) || (i == 110));
        end

        $display("[TB] table-driven sequence");
        for (int i = 0; i < NUM_VECS; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].btn);
            checkOutput($sformatf("table[%0d]", i), vecs[i].exp);
        end

        // Bounce: 2-high/2-low for 30 cycles, then held high. The final high
        // level begins at i=28, so the single LoadA lands at i=36.
        $display("[TB] bounce sequence");
        for (int i = 0; i < 48; i++) begin
            b = (i < 30) ? (((i / 2) % 2) == 0) : 1'b1;
            applyStimulus(1'b0, b);
            if (i < 36)       code = 3'd1;
            else if (i == 36) code = 3'd2;
            else              code = 3'd3;
            checkOutput($sformatf("bounce[%0d]", i),
                        pk(1'b0, (i == 36), 1'b0, 1'b0, 1'b0, code, (i == 36)));
        end

        // Reset in S_WAIT_B with the button still held high.
        $display("[TB] reset with button held");
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 1'b1);
            checkOutput($sformatf("reset_hold[%0d]", k), 9'b0);
        end

        // After release: clear once, then no press while held, nor after a
        // 3-cycle release that is too short to be accepted.
        for (int j = 0; j < 200; j++) begin
            b = (j >= 60 && j < 63) ? 1'b0 : 1'b1;
            applyStimulus(1'b0, b);
            if (j == 0)
                checkOutput("post_reset_init", pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1));
            else
                checkOutput($sformatf("post_reset_idle[%0d]", j),
                            pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0));
        end

        // A proper release followed by a fresh press gives LoadA again.
        for (int j = 0; j < 10; j++) begin
            applyStimulus(1'b0, 1'b0);
            checkOutput($sformatf("release[%0d]", j),
                        pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0));
        end
        for (int j = 0; j < 12; j++) begin
            applyStimulus(1'b0, 1'b1);
            if (j < 8)       code = 3'd1;
            else if (j == 8) code = 3'd2;
            else             code = 3'd3;
            checkOutput($sformatf("repress[%0d]", j),
                        pk(1'b0, (j == 8), 1'b0, 1'b0, 1'b0, code, (j == 8)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
